// File: rtl/bram_loader_pkg.sv
// Shared types and constants for the block-RAM loader.
//   state_t      : loader FSM states (also exported on the debug port)
//   IOCTL_ADDR_W : width of the HPS ioctl byte address
//   CSUM_W       : width of the wrapping checksum accumulator
package bram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    SUM   = 2'd3
  } state_t;

  localparam int IOCTL_ADDR_W = 25;
  localparam int CSUM_W       = 16;

endpackage

// File: rtl/bram_scan_ctr.sv
// Loadable address scanner shared by the clear pass and the checksum pass.
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   start            : load address 0 and begin a pass (ignored if limit == 0)
//   stop             : abandon the pass immediately
//   limit            : number of addresses to visit (0 .. 2^ADDR_W)
//   addr             : current address, valid while active
//   active           : a pass is in progress
//   last             : addr is the final address of the pass
// limit must stay stable for the duration of a pass.
module bram_scan_ctr #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   limit,
  output logic [ADDR_W-1:0] addr,
  output logic              active,
  output logic              last
);

  assign last = active && ({1'b0, addr} == (limit - (ADDR_W+1)'(1)));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      addr   <= '0;
      active <= 1'b0;
    end else if (stop) begin
      active <= 1'b0;
    end else if (start) begin
      addr   <= '0;
      active <= (limit != '0);
    end else if (active) begin
      if (last) active <= 1'b0;
      else      addr   <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/bram_loader.sv
// Port-B initiator for a dual-port block RAM: fills it from the HPS ioctl
// download stream, optionally clears it to CLEAR_VAL, and reads the loaded
// image back to form a 16-bit wrapping checksum.
//   clk_sys, reset_n          : clock, asynchronous active-low reset
//   start_clear               : pulse requesting a clear pass
//   ioctl_download/wr/addr/dout : HPS download stream
//   ioctl_wait                : back-pressure, high during a clear pass
//   mem_wren/addr/data, mem_q : RAM port B (mem_q registered, 1-cycle latency)
//   busy                      : FSM not idle
//   done                      : one-cycle pulse when a checksum is published
//   checksum                  : sum of loaded bytes mod 2^16
//   dl_len                    : highest in-range address written, plus 1
//   overflow                  : sticky, an out-of-range byte was dropped
//   dbg_state                 : current FSM state
// Handshake: ioctl_wr is a single-cycle strobe with no ready; the only flow
// control is ioctl_wait, and the HPS guarantees no strobe while it is high.
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] CLEAR_VAL = 8'h00
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    start_clear,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  output logic                    mem_wren,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_data,
  input  logic [7:0]              mem_q,
  output logic                    busy,
  output logic                    done,
  output logic [CSUM_W-1:0]       checksum,
  output logic [ADDR_W:0]         dl_len,
  output logic                    overflow,
  output state_t                  dbg_state
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t              state;
  logic                dl_q;
  logic                pend_load;
  logic                rd_v2;     // mem_q holds a byte to accumulate this cycle
  logic                rd_last2;  // ... and it is the final byte of the pass
  logic [CSUM_W-1:0]   acc;
  logic [ADDR_W-1:0]   wr_addr_q;

  logic                dl_rise;
  logic                in_range;
  logic [ADDR_W:0]     addr_p1;
  logic                clear_go;
  logic                sum_go;
  logic                ctr_start;
  logic                ctr_stop;
  logic [ADDR_W:0]     ctr_limit;
  logic [ADDR_W-1:0]   ctr_addr;
  logic                ctr_active;
  logic                ctr_last;
  logic [CSUM_W-1:0]   q_ext;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign in_range = (ioctl_addr[IOCTL_ADDR_W-1:ADDR_W] == '0);
  assign addr_p1  = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
  assign q_ext    = {{(CSUM_W-8){1'b0}}, mem_q};

  // A download edge outranks a simultaneous clear request.
  assign clear_go  = (state == IDLE) & start_clear & ~dl_rise;
  assign sum_go    = (state == LOAD) & ~ioctl_download & (dl_len != '0);
  assign ctr_start = clear_go | sum_go;
  assign ctr_stop  = (state == SUM) & dl_rise;
  // The limit must already be FULL on the cycle the clear pass is launched.
  assign ctr_limit = ((state == CLEAR) || clear_go) ? FULL : dl_len;

  bram_scan_ctr #(.ADDR_W(ADDR_W)) u_scan (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .start   (ctr_start),
    .stop    (ctr_stop),
    .limit   (ctr_limit),
    .addr    (ctr_addr),
    .active  (ctr_active),
    .last    (ctr_last)
  );

  // Both sources are flops and the scanner is idle during LOAD.
  assign mem_addr   = ctr_active ? ctr_addr : wr_addr_q;
  assign ioctl_wait = (state == CLEAR);
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dl_q      <= 1'b0;
      pend_load <= 1'b0;
      rd_v2     <= 1'b0;
      rd_last2  <= 1'b0;
      acc       <= '0;
      wr_addr_q <= '0;
      mem_wren  <= 1'b0;
      mem_data  <= '0;
      done      <= 1'b0;
      checksum  <= '0;
      dl_len    <= '0;
      overflow  <= 1'b0;
    end else begin
      dl_q     <= ioctl_download;
      done     <= 1'b0;
      mem_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (dl_rise) begin
            state    <= LOAD;
            dl_len   <= '0;
            overflow <= 1'b0;
          end else if (start_clear) begin
            state     <= CLEAR;
            mem_wren  <= 1'b1;
            mem_data  <= CLEAR_VAL;
            pend_load <= 1'b0;
          end
        end

        CLEAR: begin
          if (ctr_last) begin
            if (pend_load || dl_rise) begin
              state    <= LOAD;
              dl_len   <= '0;
              overflow <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            mem_wren <= 1'b1;
            if (dl_rise) pend_load <= 1'b1;
          end
        end

        LOAD: begin
          if (!ioctl_download) begin
            if (dl_len == '0) begin
              checksum <= '0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              state    <= SUM;
              acc      <= '0;
              rd_v2    <= 1'b0;
              rd_last2 <= 1'b0;
            end
          end else if (ioctl_wr) begin
            if (in_range) begin
              mem_wren  <= 1'b1;
              wr_addr_q <= ioctl_addr[ADDR_W-1:0];
              mem_data  <= ioctl_dout;
              if (addr_p1 > dl_len) dl_len <= addr_p1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end

        SUM: begin
          if (dl_rise) begin
            state    <= LOAD;
            dl_len   <= '0;
            overflow <= 1'b0;
            rd_v2    <= 1'b0;
            rd_last2 <= 1'b0;
          end else if (done) begin
            state <= IDLE;
          end else begin
            // Two-stage pipe: address out this cycle, data back the next.
            rd_v2    <= ctr_active;
            rd_last2 <= ctr_last;
            if (rd_v2) acc <= acc + q_ext;
            if (rd_last2) begin
              checksum <= acc + q_ext;
              done     <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
module tb_bram_loader;
  import bram_loader_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_clear = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        mem_wren;
  logic [AW-1:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  mem_q;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic [AW:0] dl_len;
  logic        overflow;
  state_t      dbg_state;

  always #5 clk_sys = ~clk_sys;

  bram_loader #(.ADDR_W(AW), .CLEAR_VAL(8'hFF)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .start_clear    (start_clear),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_wren       (mem_wren),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_q          (mem_q),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum),
    .dl_len         (dl_len),
    .overflow       (overflow),
    .dbg_state      (dbg_state)
  );

  // RAM port B with registered read data
  logic [7:0] ram [DEPTH];
  always @(posedge clk_sys) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  // ---------------- monitors ----------------
  logic [11:0] wr_log[$];
  int done_cnt = 0;
  int wait_cnt = 0;
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (mem_wren)   wr_log.push_back({mem_addr, mem_data});
      if (done)       done_cnt++;
      if (ioctl_wait) wait_cnt++;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  ref_mem [DEPTH];
  logic [11:0] exp_q[$];
  int          exp_len = 0;
  logic        exp_ovf = 1'b0;
  logic [15:0] last_csum = '0;
  int          st_a [32];
  logic [7:0]  st_d [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [15:0] model_sum(input int len);
    logic [15:0] s = '0;
    for (int i = 0; i < len; i++) s += 16'(ref_mem[i]);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic sb_compare(input string tag);
    int n;
    check({tag, "_count"}, wr_log.size(), exp_q.size());
    n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, wr_log[i], exp_q[i]);
    wr_log.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_pass(input bit with_dl);
    int d0;
    int cnt;
    wr_log.delete();
    exp_q.delete();
    wait_cnt = 0;
    d0 = done_cnt;
    start_clear = 1'b1;
    tick();
    start_clear = 1'b0;
    check("clr_wait_rise", ioctl_wait, 1);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({4'(i), 8'hFF});
      ref_mem[i] = 8'hFF;
    end
    if (with_dl) begin
      repeat (4) tick();
      ioctl_download = 1'b1;
    end
    cnt = 0;
    while (ioctl_wait && cnt < 100) begin
      tick();
      cnt++;
    end
    check("clr_wait_cycles", wait_cnt, DEPTH);
    sb_compare("clr_wr");
    check("clr_no_done", done_cnt - d0, 0);
    if (with_dl) begin
      check("clr_to_load", dbg_state, LOAD);
      exp_len = 0;
      exp_ovf = 1'b0;
    end else begin
      check("clr_busy_drop", busy, 0);
    end
  endtask

  task automatic start_download();
    ioctl_download = 1'b1;
    tick();
    exp_len = 0;
    exp_ovf = 1'b0;
    wr_log.delete();
    exp_q.delete();
  endtask

  task automatic load_bytes(input int nb);
    bit inr;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(st_a[i]);
      ioctl_dout = st_d[i];
      tick();
      ioctl_wr = 1'b0;
      inr = (st_a[i] < DEPTH);
      check("wr_lat_en", mem_wren, inr);
      if (inr) begin
        check("wr_lat_addr", mem_addr, st_a[i]);
        check("wr_lat_data", mem_data, st_d[i]);
        ref_mem[st_a[i]] = st_d[i];
        exp_q.push_back({4'(st_a[i]), st_d[i]});
        if (st_a[i] + 1 > exp_len) exp_len = st_a[i] + 1;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic finish_download();
    int d0;
    int cnt;
    bit seen;
    logic [15:0] csum;
    d0 = done_cnt;
    ioctl_download = 1'b0;
    cnt = 0;
    seen = 0;
    while (!seen && cnt < 60) begin
      tick();
      cnt++;
      if (done) seen = 1;
    end
    check("done_lat", cnt, (exp_len == 0) ? 1 : exp_len + 2);
    csum = (exp_len == 0) ? 16'h0 : model_sum(exp_len);
    check("checksum", checksum, csum);
    check("dl_len", dl_len, exp_len);
    check("overflow", overflow, exp_ovf);
    last_csum = csum;
    tick();
    check("done_pulse", done, 0);
    check("idle_after", busy, 0);
    check("done_once", done_cnt - d0, 1);
    sb_compare("ld_wr");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wait"}, ioctl_wait, 0);
    check({tag, "_wren"}, mem_wren, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_data"}, mem_data, 0);
    check({tag, "_csum"}, checksum, 0);
    check({tag, "_len"}, dl_len, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    repeat (3) tick();
    check_all_zero("rst");
    reset_n = 1'b1;
    tick();

    // clear pass
    clear_pass(0);

    // load 01..04 and checksum
    start_download();
    for (int i = 0; i < 4; i++) begin
      st_a[i] = i;
      st_d[i] = 8'(i + 1);
    end
    load_bytes(4);
    finish_download();
    check("csum_0a", checksum, 16'h000A);

    // sparse load with an out-of-range byte over a cleared RAM
    clear_pass(0);
    start_download();
    st_a[0] = 5;  st_d[0] = 8'h80;
    st_a[1] = 20; st_d[1] = 8'h11;
    load_bytes(2);
    finish_download();
    check("csum_57b", checksum, 16'h057B);

    // empty download
    start_download();
    repeat (2) tick();
    finish_download();

    // start_clear coinciding with the download edge
    wr_log.delete();
    exp_q.delete();
    start_clear = 1'b1;
    ioctl_download = 1'b1;
    tick();
    start_clear = 1'b0;
    exp_len = 0;
    exp_ovf = 1'b0;
    repeat (3) tick();
    check("coll_state", dbg_state, LOAD);
    check("coll_wait", ioctl_wait, 0);
    finish_download();

    // download edge in the middle of a clear pass
    clear_pass(1);
    for (int i = 0; i < 5; i++) begin
      st_a[i] = $urandom_range(0, DEPTH - 1);
      st_d[i] = 8'($urandom);
    end
    load_bytes(5);
    finish_download();

    // download edge during SUM aborts the checksum
    start_download();
    for (int i = 0; i < 8; i++) begin
      st_a[i] = i;
      st_d[i] = 8'($urandom);
    end
    load_bytes(8);
    d0 = done_cnt;
    ioctl_download = 1'b0;
    tick();
    tick();
    ioctl_download = 1'b1;
    repeat (12) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_csum_kept", checksum, last_csum);
    check("abort_state", dbg_state, LOAD);
    check("abort_len_clr", dl_len, 0);
    sb_compare("abort_wr");
    exp_len = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st_a[i] = $urandom_range(0, 20);
      st_d[i] = 8'($urandom);
    end
    load_bytes(3);
    finish_download();

    // randomized downloads
    for (int it = 0; it < 8; it++) begin
      int nb;
      start_download();
      nb = $urandom_range(1, 10);
      for (int i = 0; i < nb; i++) begin
        st_a[i] = $urandom_range(0, 20);
        st_d[i] = 8'($urandom);
      end
      load_bytes(nb);
      finish_download();
    end

    // reset in the middle of a download
    start_download();
    st_a[0] = 3; st_d[0] = 8'h5A;
    load_bytes(1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    ioctl_download = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
